// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO peripheral: bus command encoding and the
// default peripheral addresses also used by the CPU/RAM address decode.
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MWRITE   = 2'b10,
    MILLEGAL = 2'b11
  } mem_cmd_t;

  localparam int unsigned DATA_WIDTH_D = 16;
  localparam int unsigned ADDR_WIDTH_D = 9;

  localparam logic [ADDR_WIDTH_D-1:0] LED_ADDR_D = 9'h100;
  localparam logic [ADDR_WIDTH_D-1:0] HEX_ADDR_D = 9'h120;
  localparam logic [ADDR_WIDTH_D-1:0] SW_ADDR_D  = 9'h140;

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU memory-bus bundle seen by the MMIO peripheral.
interface mmio_io_ctrl_if
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_D,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_D
) ();

  mem_cmd_t              mem_cmd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  rd_hit;

  modport master (
    output mem_cmd, mem_addr, write_data,
    input  read_data, rd_hit
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data,
    output read_data, rd_hit
  );

endinterface

// File: rtl/mmio_io_ctrl_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous bus into the clk domain.
module sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // Shift the raw input one stage further on every clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the synchroniser flops are reset as well, so the switch port reads a known 0 after reset.
      stage <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its predecessor's old value, giving a true chain.
      stage[0] <= din;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O peripheral: LED register, display register with a timed
// update indicator, synchronised switch port and a sticky bus-error flag.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = DATA_WIDTH_D,
  parameter int unsigned           ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR     = LED_ADDR_D,
  parameter logic [ADDR_WIDTH-1:0] HEX_ADDR     = HEX_ADDR_D,
  parameter logic [ADDR_WIDTH-1:0] SW_ADDR      = SW_ADDR_D,
  parameter int unsigned           SYNC_STAGES  = 2,
  parameter int unsigned           PULSE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mmio_io_ctrl_if.slave         bus,
  input  logic [7:0]            sw_in,
  output logic [7:0]            led_out,
  output logic [DATA_WIDTH-1:0] hex_value,
  output logic                  upd_flag,
  output logic                  err_flag
);

  localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);

  logic [7:0]            sw_sync;
  logic [CNT_W-1:0]      pulse_cnt;
  logic                  hit_led;
  logic                  hit_hex;
  logic                  hit_sw;
  logic [DATA_WIDTH-1:0] rd_mux;

  sync_chain #(
    .WIDTH  (8),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sw_in),
    .dout    (sw_sync)
  );

  // Full-width address compare: no partial decode, no aliasing.
  assign hit_led = (bus.mem_addr == LED_ADDR);
  assign hit_hex = (bus.mem_addr == HEX_ADDR);
  assign hit_sw  = (bus.mem_addr == SW_ADDR);

  // Unmapped reads return 0; the hex path sees the value before any write this cycle.
  assign rd_mux = hit_sw  ? DATA_WIDTH'(sw_sync) :
                  hit_led ? DATA_WIDTH'(led_out) :
                  hit_hex ? hex_value            :
                            '0;

  // The indicator is a pure decode of the registered counter, so it cannot glitch on a retrigger.
  assign upd_flag = (pulse_cnt != '0);

  // Bus command handling: register writes, read response, pulse counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out       <= '0;
      hex_value     <= '0;
      pulse_cnt     <= '0;
      err_flag      <= 1'b0;
      bus.read_data <= '0;
      bus.rd_hit    <= 1'b0;
    end else begin
      // Count down by default; a display write below overrides this with a reload.
      if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - CNT_W'(1);
      end

      unique case (bus.mem_cmd)
        MREAD: begin
          bus.read_data <= rd_mux;
          bus.rd_hit    <= hit_sw | hit_led | hit_hex;
        end
        MWRITE: begin
          bus.rd_hit <= 1'b0;
          if (hit_led) begin
            led_out <= bus.write_data[7:0];
          end else if (hit_hex) begin
            hex_value <= bus.write_data;
            pulse_cnt <= CNT_W'(PULSE_CYCLES);
          end else begin
            // Switch port is read-only and unmapped writes have no owner here.
            err_flag <= 1'b1;
          end
        end
        MILLEGAL: begin
          bus.rd_hit <= 1'b0;
          err_flag   <= 1'b1;
        end
        default: begin
          bus.rd_hit <= 1'b0;
        end
      endcase
    end
  end

endmodule
